// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: multiply-unit sequencer and owner of the architectural HI/LO pair.
// Issues registered operands to a one-cycle multiplier, waits for its ready pulse,
// then commits the product to HI/LO, accumulates it (MADD/MSUB) or returns the low
// word to the GPR file (MUL). Holds the pipeline while an operation is in flight.
module hilo_mdu_ctrl #(
   parameter logic [63:0] HILO_RESET = 64'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [3:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        stall,
   output logic        gpr_valid,
   output logic [31:0] gpr_result,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_sign,
   output logic        mul_start,
   input  logic [63:0] mul_result,
   input  logic        mul_ready
);

   // Operation encoding as presented by EX.
   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_MADD  = 4'd3;
   localparam logic [3:0] OP_MADDU = 4'd4;
   localparam logic [3:0] OP_MSUB  = 4'd5;
   localparam logic [3:0] OP_MSUBU = 4'd6;
   localparam logic [3:0] OP_MUL   = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;
   localparam logic [3:0] OP_MTLO  = 4'd9;

   // Sequencer states.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_ACC   = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   logic [2:0]  state_q,      state_d;
   logic [3:0]  op_q,         op_d;
   logic [63:0] hilo_q,       hilo_d;
   logic [63:0] prod_q,       prod_d;
   logic [31:0] mul_a_q,      mul_a_d;
   logic [31:0] mul_b_q,      mul_b_d;
   logic        mul_sign_q,   mul_sign_d;
   logic [31:0] gpr_result_q, gpr_result_d;

   logic op_is_mdu;      // op needs the multiplier (MULT .. MUL)
   logic op_is_signed;   // signed multiply flavour
   logic acc_is_add;     // latched op accumulates upward (MADD/MADDU)
   logic issue;          // an MDU op leaves IDLE this cycle

   // Decode the incoming op and the latched op.
   always_comb begin
      op_is_mdu    = (op >= OP_MULT) && (op <= OP_MUL);
      op_is_signed = (op == OP_MULT) || (op == OP_MADD) ||
                     (op == OP_MSUB) || (op == OP_MUL);
      acc_is_add   = (op_q == OP_MADD) || (op_q == OP_MADDU);
      issue        = (state_q == ST_IDLE) && op_valid && !flush && op_is_mdu;
   end

   // Next-state and datapath update for the sequencer and HI/LO.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      op_d         = op_q;
      hilo_d       = hilo_q;
      prod_d       = prod_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      mul_sign_d   = mul_sign_q;
      gpr_result_d = gpr_result_q;

      case (state_q)
         ST_IDLE: begin
            if (op_valid && !flush) begin
               if (op_is_mdu) begin
                  mul_a_d    = rs_val;
                  mul_b_d    = rt_val;
                  mul_sign_d = op_is_signed;
                  op_d       = op;
                  state_d    = ST_WAIT;
               end else if (op == OP_MTHI) begin
                  hilo_d[63:32] = rs_val;
               end else if (op == OP_MTLO) begin
                  hilo_d[31:0] = rs_val;
               end
            end
         end

         ST_WAIT: begin
            if (flush) begin
               // A killed op writes nothing. If the product has not arrived yet the
               // multiplier will still pulse ready, so that pulse must be absorbed.
               state_d = mul_ready ? ST_IDLE : ST_DRAIN;
            end else if (mul_ready) begin
               prod_d = mul_result;
               case (op_q)
                  OP_MULT, OP_MULTU: begin
                     hilo_d  = mul_result;
                     state_d = ST_DONE;
                  end
                  OP_MUL: begin
                     gpr_result_d = mul_result[31:0];
                     state_d      = ST_DONE;
                  end
                  default: begin
                     state_d = ST_ACC;
                  end
               endcase
            end
         end

         ST_ACC: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               // 64-bit modulo arithmetic: carry/borrow out of bit 63 is dropped.
               hilo_d  = acc_is_add ? (hilo_q + prod_q) : (hilo_q - prod_q);
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            // op_valid still shows the instruction just completed, so it is ignored.
            state_d = ST_IDLE;
         end

         ST_DRAIN: begin
            if (mul_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pipeline hold, multiplier start and GPR writeback strobe.
   always_comb begin
      stall     = issue ||
                  (state_q == ST_WAIT) ||
                  (state_q == ST_ACC) ||
                  ((state_q == ST_DRAIN) && op_valid);
      mul_start = (state_q == ST_WAIT);
      gpr_valid = (state_q == ST_DONE) && (op_q == OP_MUL);
   end

   // State registers with synchronous reset; a reset mid-operation abandons it.
   always_ff @(posedge clk) begin
      // NOTE: clocked state is assigned non-blocking so every flop samples the pre-edge values.
      if (rst) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_NOP;
         hilo_q       <= HILO_RESET;
         prod_q       <= 64'd0;
         mul_a_q      <= 32'd0;
         mul_b_q      <= 32'd0;
         mul_sign_q   <= 1'b0;
         gpr_result_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         hilo_q       <= hilo_d;
         prod_q       <= prod_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         mul_sign_q   <= mul_sign_d;
         gpr_result_q <= gpr_result_d;
      end
   end

   assign hi         = hilo_q[63:32];
   assign lo         = hilo_q[31:0];
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign mul_sign   = mul_sign_q;
   assign gpr_result = gpr_result_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Bench for hilo_mdu_ctrl: a one-cycle multiplier model plus a HI/LO/GPR reference
// computed directly from the instruction semantics with 64-bit arithmetic.
module tb_hilo_mdu_ctrl;

   localparam logic [63:0] HILO_R = 64'h0123_4567_89AB_CDEF;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_MADD  = 4'd3;
   localparam logic [3:0] OP_MADDU = 4'd4;
   localparam logic [3:0] OP_MSUB  = 4'd5;
   localparam logic [3:0] OP_MSUBU = 4'd6;
   localparam logic [3:0] OP_MUL   = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;
   localparam logic [3:0] OP_MTLO  = 4'd9;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [3:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        stall;
   logic        gpr_valid;
   logic [31:0] gpr_result;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_sign;
   logic        mul_start;
   logic [63:0] mul_result;
   logic        mul_ready;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] m_hilo;   // reference {hi,lo}
   logic [31:0] m_gpr;    // reference gpr_result

   hilo_mdu_ctrl #(.HILO_RESET(HILO_R)) dut (
      .clk        (clk),
      .rst        (rst),
      .op_valid   (op_valid),
      .op         (op),
      .rs_val     (rs_val),
      .rt_val     (rt_val),
      .flush      (flush),
      .stall      (stall),
      .gpr_valid  (gpr_valid),
      .gpr_result (gpr_result),
      .hi         (hi),
      .lo         (lo),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_sign   (mul_sign),
      .mul_start  (mul_start),
      .mul_result (mul_result),
      .mul_ready  (mul_ready)
   );

   always #5 clk = ~clk;

   // One-cycle multiplier: ready pulses the cycle after start is sampled, result held.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_ready  <= 1'b0;
         mul_result <= 64'd0;
      end else if (mul_start && !mul_ready) begin
         mul_ready  <= 1'b1;
         mul_result <= (mul_sign ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a}) *
                       (mul_sign ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b});
      end else begin
         mul_ready  <= 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      next_cycle();
      op_valid = 1'b0;
      flush    = 1'b0;
      #1;
   endtask

   // Issue one op and follow it to completion, checking every cycle against the reference.
   task automatic exec_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp_hilo;
      logic [31:0] exp_gpr;
      logic [63:0] up;
      logic [63:0] prod;
      longint      sp;
      logic        mdu;
      logic        sgn;
      logic        acc;
      logic        is_mul;
      mdu    = (o >= OP_MULT) && (o <= OP_MUL);
      sgn    = (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB) || (o == OP_MUL);
      acc    = (o >= OP_MADD) && (o <= OP_MSUBU);
      is_mul = (o == OP_MUL);
      sp     = longint'($signed(a)) * longint'($signed(b));
      up     = {32'd0, a} * {32'd0, b};
      prod   = sgn ? 64'(sp) : up;
      exp_hilo = m_hilo;
      exp_gpr  = m_gpr;
      case (o)
         OP_MULT, OP_MULTU: exp_hilo = prod;
         OP_MADD, OP_MADDU: exp_hilo = m_hilo + prod;
         OP_MSUB, OP_MSUBU: exp_hilo = m_hilo - prod;
         OP_MUL:            exp_gpr  = prod[31:0];
         OP_MTHI:           exp_hilo[63:32] = a;
         OP_MTLO:           exp_hilo[31:0]  = a;
         default: ;
      endcase

      next_cycle();
      op_valid = 1'b1; op = o; rs_val = a; rt_val = b; flush = 1'b0;
      #1;
      n_cmp++;
      if ({stall, mul_start, gpr_valid} !== {mdu, 2'b00}) begin
         n_bad++;
         $display("FAIL op%0d issue stall/start/gvalid: got %b want %b", o, {stall, mul_start, gpr_valid}, {mdu, 2'b00});
      end
      if (!mdu) begin
         next_cycle();
         op_valid = 1'b0;
         #1;
         n_cmp++;
         if ({hi, lo} !== exp_hilo) begin
            n_bad++;
            $display("FAIL op%0d move hilo: got %h want %h", o, {hi, lo}, exp_hilo);
         end
      end else begin
         next_cycle(); #1;
         n_cmp++;
         if ({stall, mul_start, gpr_valid} !== 3'b110) begin
            n_bad++;
            $display("FAIL op%0d wait1 stall/start/gvalid: got %b want 110", o, {stall, mul_start, gpr_valid});
         end
         n_cmp++;
         if ({mul_a, mul_b, mul_sign} !== {a, b, sgn}) begin
            n_bad++;
            $display("FAIL op%0d operands a/b/sign: got %h %h %b want %h %h %b", o, mul_a, mul_b, mul_sign, a, b, sgn);
         end
         next_cycle(); #1;
         n_cmp++;
         if ({stall, mul_start, gpr_valid, mul_ready} !== 4'b1101) begin
            n_bad++;
            $display("FAIL op%0d wait2 stall/start/gvalid/ready: got %b want 1101", o, {stall, mul_start, gpr_valid, mul_ready});
         end
         n_cmp++;
         if ({hi, lo} !== m_hilo) begin
            n_bad++;
            $display("FAIL op%0d early hilo: got %h want %h", o, {hi, lo}, m_hilo);
         end
         if (acc) begin
            next_cycle(); #1;
            n_cmp++;
            if ({stall, mul_start, gpr_valid} !== 3'b100) begin
               n_bad++;
               $display("FAIL op%0d acc stall/start/gvalid: got %b want 100", o, {stall, mul_start, gpr_valid});
            end
         end
         next_cycle(); #1;
         n_cmp++;
         if ({stall, mul_start, gpr_valid} !== {2'b00, is_mul}) begin
            n_bad++;
            $display("FAIL op%0d done stall/start/gvalid: got %b want %b", o, {stall, mul_start, gpr_valid}, {2'b00, is_mul});
         end
         n_cmp++;
         if ({hi, lo, gpr_result} !== {exp_hilo, exp_gpr}) begin
            n_bad++;
            $display("FAIL op%0d result hilo/gpr: got %h %h want %h %h", o, {hi, lo}, gpr_result, exp_hilo, exp_gpr);
         end
      end
      m_hilo = exp_hilo;
      m_gpr  = exp_gpr;
   endtask

   task automatic test_reset();
      rst = 1'b1; op_valid = 1'b1; op = OP_MTHI; rs_val = 32'hDEAD_BEEF; rt_val = 32'd0; flush = 1'b0;
      repeat (3) next_cycle();
      rst = 1'b0; op_valid = 1'b0;
      #1;
      m_hilo = HILO_R;
      m_gpr  = 32'd0;
      n_cmp++;
      if ({hi, lo} !== HILO_R) begin
         n_bad++;
         $display("FAIL reset hilo: got %h want %h", {hi, lo}, HILO_R);
      end
      n_cmp++;
      if ({stall, gpr_valid, mul_start, mul_sign, mul_a, mul_b, gpr_result} !== 100'd0) begin
         n_bad++;
         $display("FAIL reset outputs: got %b%b%b%b %h %h %h want all zero", stall, gpr_valid, mul_start, mul_sign, mul_a, mul_b, gpr_result);
      end
   endtask

   task automatic test_directed();
      exec_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n_cmp++;
      if ({hi, lo} !== 64'h0000_0000_0000_0001) begin
         n_bad++;
         $display("FAIL mult_neg1 hilo: got %h want 0000000000000001", {hi, lo});
      end
      exec_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n_cmp++;
      if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
         n_bad++;
         $display("FAIL multu_max hilo: got %h want fffffffe00000001", {hi, lo});
      end
      exec_op(OP_MTHI, 32'h0000_0001, 32'd0);
      exec_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
      exec_op(OP_MADDU, 32'd1, 32'd1);
      n_cmp++;
      if ({hi, lo} !== 64'h0000_0002_0000_0000) begin
         n_bad++;
         $display("FAIL maddu_carry hilo: got %h want 0000000200000000", {hi, lo});
      end
      exec_op(OP_MTHI, 32'd0, 32'd0);
      exec_op(OP_MTLO, 32'd0, 32'd0);
      exec_op(OP_MSUB, 32'd2, 32'd3);
      n_cmp++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         n_bad++;
         $display("FAIL msub_wrap hilo: got %h want fffffffffffffffa", {hi, lo});
      end
      exec_op(OP_MUL, 32'h7FFF_FFFF, 32'd2);
      n_cmp++;
      if ({gpr_valid, gpr_result, hi, lo} !== {1'b1, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA}) begin
         n_bad++;
         $display("FAIL mul_low gvalid/gpr/hilo: got %b %h %h want 1 fffffffe fffffffffffffffa", gpr_valid, gpr_result, {hi, lo});
      end
      idle_cycle();
      n_cmp++;
      if (gpr_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL mul_pulse gpr_valid after done: got %b want 0", gpr_valid);
      end
   endtask

   task automatic test_back_to_back();
      exec_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
      exec_op(OP_MADD,  32'h8000_0000, 32'h8000_0000);
      exec_op(OP_MUL,   32'hFFFF_FFFD, 32'h0000_0007);
      exec_op(OP_MSUBU, 32'hFFFF_FFFF, 32'h0000_0002);
      exec_op(OP_MTLO,  32'hCAFE_F00D, 32'd0);
      exec_op(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      // Flush arriving in DONE must not undo the commit.
      flush = 1'b1;
      idle_cycle();
      n_cmp++;
      if ({hi, lo} !== m_hilo) begin
         n_bad++;
         $display("FAIL done_flush hilo: got %h want %h", {hi, lo}, m_hilo);
      end
   endtask

   task automatic test_flush();
      logic [3:0] fops [3];
      fops = '{OP_MULT, OP_MUL, OP_MADD};
      // Flush in IDLE: neither an MDU op nor a move takes effect.
      next_cycle();
      op_valid = 1'b1; op = OP_MULT; rs_val = 32'd5; rt_val = 32'd6; flush = 1'b1;
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_flush stall: got %b want 0", stall);
      end
      next_cycle();
      op = OP_MTHI; rs_val = 32'h5555_AAAA;
      #1;
      n_cmp++;
      if ({stall, mul_start} !== 2'b00) begin
         n_bad++;
         $display("FAIL idle_flush no issue stall/start: got %b want 00", {stall, mul_start});
      end
      idle_cycle();
      n_cmp++;
      if ({hi, lo, mul_start} !== {m_hilo, 1'b0}) begin
         n_bad++;
         $display("FAIL idle_flush hilo/start: got %h %b want %h 0", {hi, lo}, mul_start, m_hilo);
      end

      // Flush in the first WAIT cycle: DRAIN swallows the late ready, new op held off.
      next_cycle();
      op_valid = 1'b1; op = OP_MULT; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000; flush = 1'b0;
      next_cycle();
      flush = 1'b1;
      #1;
      n_cmp++;
      if ({stall, mul_start} !== 2'b11) begin
         n_bad++;
         $display("FAIL wait_flush stall/start: got %b want 11", {stall, mul_start});
      end
      next_cycle();
      flush = 1'b0; op = OP_MULTU; rs_val = 32'h89AB_CDEF; rt_val = 32'h0000_0010;
      #1;
      n_cmp++;
      if ({stall, mul_start, gpr_valid, mul_ready} !== 4'b1001) begin
         n_bad++;
         $display("FAIL drain stall/start/gvalid/ready: got %b want 1001", {stall, mul_start, gpr_valid, mul_ready});
      end
      exec_op(OP_MULTU, 32'h89AB_CDEF, 32'h0000_0010);

      // Flush in the WAIT cycle that sees ready: nothing written, straight back to IDLE.
      foreach (fops[i]) begin
         next_cycle();
         op_valid = 1'b1; op = fops[i]; rs_val = $urandom; rt_val = $urandom; flush = 1'b0;
         next_cycle();
         next_cycle();
         flush = 1'b1;
         #1;
         n_cmp++;
         if (mul_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_flush op%0d ready: got %b want 1", fops[i], mul_ready);
         end
         idle_cycle();
         n_cmp++;
         if ({stall, mul_start, gpr_valid, hi, lo, gpr_result} !== {3'b000, m_hilo, m_gpr}) begin
            n_bad++;
            $display("FAIL ready_flush op%0d ctrl/hilo/gpr: got %b %h %h want 000 %h %h", fops[i], {stall, mul_start, gpr_valid}, {hi, lo}, gpr_result, m_hilo, m_gpr);
         end
      end

      // Flush in ACC: the accumulate is dropped.
      next_cycle();
      op_valid = 1'b1; op = OP_MSUBU; rs_val = 32'h0000_1000; rt_val = 32'h0000_0100; flush = 1'b0;
      next_cycle();
      next_cycle();
      next_cycle();
      flush = 1'b1;
      idle_cycle();
      n_cmp++;
      if ({stall, gpr_valid, hi, lo} !== {2'b00, m_hilo}) begin
         n_bad++;
         $display("FAIL acc_flush stall/gvalid/hilo: got %b %h want 00 %h", {stall, gpr_valid}, {hi, lo}, m_hilo);
      end
   endtask

   task automatic test_mid_reset();
      next_cycle();
      op_valid = 1'b1; op = OP_MADD; rs_val = 32'h0000_0003; rt_val = 32'hFFFF_FFF0; flush = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b1; op_valid = 1'b0;
      next_cycle();
      rst = 1'b0;
      #1;
      m_hilo = HILO_R;
      m_gpr  = 32'd0;
      n_cmp++;
      if ({hi, lo, stall, mul_start, gpr_valid, mul_sign, mul_a} !== {HILO_R, 36'd0}) begin
         n_bad++;
         $display("FAIL mid_reset hilo/ctrl/a: got %h %b %h want %h 0000 0", {hi, lo}, {stall, mul_start, gpr_valid, mul_sign}, mul_a, HILO_R);
      end
      idle_cycle();
      n_cmp++;
      if ({hi, lo} !== HILO_R) begin
         n_bad++;
         $display("FAIL mid_reset late write hilo: got %h want %h", {hi, lo}, HILO_R);
      end
   endtask

   task automatic test_random();
      logic [31:0] corner [4];
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  o;
      corner = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      for (int i = 0; i < 60; i++) begin
         o = 4'($urandom_range(1, 9));
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         exec_op(o, a, b);
         if ($urandom_range(0, 2) == 0) idle_cycle();
      end
      idle_cycle();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
